// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive controller slice.
//   - state_t     : controller states (OFF, CRST, RUN, RECONF)
//   - CRST_CYCLES : number of cycles the core reset is held on each (re)start
//   - PRESCALE_W  : width of the prescale configuration bus
package uart_pkg;

  localparam int PRESCALE_W  = 16;
  localparam int CRST_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_CRST   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RECONF = 2'd3
  } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Synchronous FIFO with a registered head. Pushed data becomes visible on
//   o_data one cycle after the push edge (no fall-through). A push into a
//   full FIFO is accepted when a pop happens in the same cycle.
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   i_flush   : synchronous flush; empties the FIFO and blocks any push
//   i_push    : write request, i_data is the written word
//   i_pop     : read request; ignored when empty
//   o_data    : registered head word, stable while not popped
//   o_valid   : FIFO non-empty
//   o_full    : FIFO holds DEPTH words
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_push = i_push && !i_flush && ((r_count != FULL_CNT) || w_pop);

  assign w_rd_next = w_pop ? AW'(r_rd_ptr + 1'b1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Registered read of the next head entry. The slot being written this
  // cycle is not yet in r_mem, so it is bypassed from i_data when it is the
  // one that becomes the head (empty FIFO, or last entry popped).
  always_comb begin
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_next)) begin
        w_head_next = i_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Controller between a UART receive core and downstream consumers. Owns
//   the core reset and prescale, restarts the core safely (never mid-frame)
//   on a prescale change or frame-error re-arm, buffers received bytes in a
//   small FIFO (the core is never back-pressured) and keeps sticky
//   overrun/frame-error status and a saturating drop counter.
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   cfg_enable           : receiver enable level; low forces OFF next cycle
//   cfg_prescale         : requested prescale
//   status_clear         : pulse clearing overrun, frame_error, drop_count
//   rx_rst, rx_prescale  : reset and prescale driven to the core
//   rx_tdata/tvalid/tready, rx_busy, rx_frame_error : core interface
//   m_axis_tdata/tvalid/tready : FIFO output stream
//   overrun, frame_error, drop_count : status
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  status_clear,
  output logic                  rx_rst,
  output logic [PRESCALE_W-1:0] rx_prescale,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic                  rx_busy,
  input  logic                  rx_frame_error,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overrun,
  output logic                  frame_error,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam logic [1:0] CRST_LAST = 2'(CRST_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_crst_cnt;
  logic [PRESCALE_W-1:0] r_rx_prescale;
  logic                  r_fe_d;
  logic                  r_overrun;
  logic                  r_frame_error;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic w_rx_rst;
  logic w_rx_tready;
  logic w_beat;
  logic w_pop;
  logic w_full;
  logic w_drop;
  logic w_flush;
  logic w_fe_rise;

  assign w_rx_rst    = (r_state == ST_OFF) || (r_state == ST_CRST);
  assign w_rx_tready = (r_state == ST_RUN) || (r_state == ST_RECONF);
  assign w_beat      = rx_tvalid && w_rx_tready;
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_drop      = w_beat && w_full && !w_pop;
  // Flushing already on the disabling edge makes m_axis_tvalid drop in the
  // same cycle the controller lands in OFF.
  assign w_flush     = (r_state == ST_OFF) || !cfg_enable;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF: begin
        if (cfg_enable) w_state_next = ST_CRST;
      end
      ST_CRST: begin
        if (r_crst_cnt == CRST_LAST) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if ((cfg_prescale != r_rx_prescale) || (status_clear && rx_frame_error)) begin
          w_state_next = ST_RECONF;
        end
      end
      ST_RECONF: begin
        // Restart only between frames and with no byte in flight.
        if (!rx_busy && !rx_tvalid) w_state_next = ST_CRST;
      end
      default: w_state_next = ST_OFF;
    endcase
    if (!cfg_enable) w_state_next = ST_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_OFF;
      r_crst_cnt    <= '0;
      r_rx_prescale <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_CRST) && (w_state_next == ST_CRST)) begin
        r_crst_cnt <= 2'(r_crst_cnt + 1'b1);
      end else begin
        r_crst_cnt <= '0;
      end
      if ((w_state_next == ST_CRST) && (r_state != ST_CRST)) begin
        r_rx_prescale <= cfg_prescale;
      end
    end
  end

  // Edge detect on the core flag; held low while the core is in reset so
  // the flag clearing/reasserting across a core reset reads as a fresh edge.
  assign w_fe_rise = rx_frame_error && !r_fe_d && !w_rx_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fe_d        <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_fe_d <= w_rx_rst ? 1'b0 : rx_frame_error;

      // A set event in the same cycle as status_clear wins.
      if (w_fe_rise) begin
        r_frame_error <= 1'b1;
      end else if (status_clear) begin
        r_frame_error <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (status_clear) begin
        r_overrun <= 1'b0;
      end

      if (w_drop) begin
        if (status_clear) begin
          r_drop_count <= CNT_WIDTH'(1);
        end else if (!(&r_drop_count)) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end else if (status_clear) begin
        r_drop_count <= '0;
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_beat),
    .i_data  (rx_tdata),
    .i_pop   (m_axis_tready),
    .o_data  (m_axis_tdata),
    .o_valid (m_axis_tvalid),
    .o_full  (w_full)
  );

  assign rx_rst      = w_rx_rst;
  assign rx_tready   = w_rx_tready;
  assign rx_prescale = r_rx_prescale;
  assign overrun     = r_overrun;
  assign frame_error = r_frame_error;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed stimulus with a byte scoreboard: accepted bytes are queued when
//   driven, and a negedge monitor pops and compares on every m_axis transfer.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [15:0] cfg_prescale;
  logic        status_clear;
  logic        rx_rst;
  logic [15:0] rx_prescale;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic        rx_busy;
  logic        rx_frame_error;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overrun;
  logic        frame_error;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_enable     (cfg_enable),
    .cfg_prescale   (cfg_prescale),
    .status_clear   (status_clear),
    .rx_rst         (rx_rst),
    .rx_prescale    (rx_prescale),
    .rx_tdata       (rx_tdata),
    .rx_tvalid      (rx_tvalid),
    .rx_tready      (rx_tready),
    .rx_busy        (rx_busy),
    .rx_frame_error (rx_frame_error),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .overrun        (overrun),
    .frame_error    (frame_error),
    .drop_count     (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    if (keep) exp_q.push_back(b);
    tick();
    rx_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || m_axis_tvalid); i++) tick();
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_tvalid_low"}, {31'd0, m_axis_tvalid}, 0);
  endtask

  task automatic wait_rx_rst(input logic level, input string name);
    for (int i = 0; i < 10 && rx_rst !== level; i++) tick();
    chk(name, {31'd0, rx_rst}, {31'd0, level});
  endtask

  // Scoreboard monitor: one line per transfer.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL m_axis_unexpected: got 0x%0h expected none", m_axis_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_axis_tdata !== mon_exp) begin
          failures++;
          $display("FAIL m_axis_data: got 0x%0h expected 0x%0h", m_axis_tdata, mon_exp);
        end else begin
          $display("xfer data=0x%0h ok", m_axis_tdata);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_prescale = 16'd0; status_clear = 1'b0;
    rx_tdata = 8'd0; rx_tvalid = 1'b0; rx_busy = 1'b0; rx_frame_error = 1'b0;
    m_axis_tready = 1'b0;
    #12;
    chk("rst_rx_rst", {31'd0, rx_rst}, 1);
    chk("rst_prescale", {16'd0, rx_prescale}, 0);
    chk("rst_rx_tready", {31'd0, rx_tready}, 0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_frame_error", {31'd0, frame_error}, 0);
    chk("rst_drop_count", {24'd0, drop_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Enable: two core-reset cycles, then RUN with prescale 16.
    cfg_prescale = 16'd16; cfg_enable = 1'b1; m_axis_tready = 1'b1;
    tick();
    chk("crst1_rx_rst", {31'd0, rx_rst}, 1);
    chk("crst1_prescale", {16'd0, rx_prescale}, 16);
    chk("crst1_rx_tready", {31'd0, rx_tready}, 0);
    tick();
    chk("crst2_rx_rst", {31'd0, rx_rst}, 1);
    tick();
    chk("run_rx_rst", {31'd0, rx_rst}, 0);
    chk("run_rx_tready", {31'd0, rx_tready}, 1);
    $display("enable done prescale=%0d", rx_prescale);

    // Two bytes, one-cycle latency, in order.
    rx_tdata = 8'h55; rx_tvalid = 1'b1; exp_q.push_back(8'h55);
    chk("no_fallthrough", {31'd0, m_axis_tvalid}, 0);
    tick();
    chk("lat_valid_55", {31'd0, m_axis_tvalid}, 1);
    chk("lat_data_55", {24'd0, m_axis_tdata}, 32'h55);
    rx_tdata = 8'hA3; exp_q.push_back(8'hA3);
    tick();
    rx_tvalid = 1'b0;
    chk("lat_data_a3", {24'd0, m_axis_tdata}, 32'hA3);
    tick();
    chk("after_a3_empty", {31'd0, m_axis_tvalid}, 0);

    // Overflow: 6 bytes into a 4-deep FIFO with no consumer.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), i < 4);
    chk("ovf_overrun", {31'd0, overrun}, 1);
    chk("ovf_drop_count", {24'd0, drop_count}, 2);
    chk("ovf_head", {24'd0, m_axis_tdata}, 32'h10);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    chk("clr_overrun", {31'd0, overrun}, 0);
    chk("clr_drop_count", {24'd0, drop_count}, 0);
    drain("ovf_drain");

    // Full FIFO with simultaneous push and pop.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h24 + 8'(i), 1'b1);
    chk("pp_overrun", {31'd0, overrun}, 0);
    chk("pp_drop_count", {24'd0, drop_count}, 0);
    drain("pp_drain");

    // Drop counter saturation and set-wins-over-clear.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < 258; i++) send(8'(i), 1'b0);
    chk("sat_drop_count", {24'd0, drop_count}, 255);
    chk("sat_overrun", {31'd0, overrun}, 1);
    rx_tdata = 8'hEE; rx_tvalid = 1'b1; status_clear = 1'b1;
    tick();
    rx_tvalid = 1'b0; status_clear = 1'b0;
    chk("setwin_drop_count", {24'd0, drop_count}, 1);
    chk("setwin_overrun", {31'd0, overrun}, 1);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    chk("clr2_drop_count", {24'd0, drop_count}, 0);
    chk("clr2_overrun", {31'd0, overrun}, 0);
    drain("sat_drain");

    // Prescale change during a frame.
    m_axis_tready = 1'b0;
    send(8'h30, 1'b1);
    send(8'h31, 1'b1);
    rx_busy = 1'b1; cfg_prescale = 16'd32;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reconf_busy_rx_rst", {31'd0, rx_rst}, 0);
    end
    chk("reconf_old_prescale", {16'd0, rx_prescale}, 16);
    chk("reconf_rx_tready", {31'd0, rx_tready}, 1);
    rx_busy = 1'b0;
    send(8'h32, 1'b1);
    chk("reconf_tvalid_rx_rst", {31'd0, rx_rst}, 0);
    tick();
    chk("reconf_crst1_rx_rst", {31'd0, rx_rst}, 1);
    chk("reconf_new_prescale", {16'd0, rx_prescale}, 32);
    tick();
    chk("reconf_crst2_rx_rst", {31'd0, rx_rst}, 1);
    tick();
    chk("reconf_run_rx_rst", {31'd0, rx_rst}, 0);
    chk("reconf_fifo_head", {24'd0, m_axis_tdata}, 32'h30);
    drain("reconf_drain");

    // Frame error set, re-arm through a core reset, set again.
    rx_frame_error = 1'b1;
    tick(); tick();
    chk("fe_set", {31'd0, frame_error}, 1);
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    chk("fe_cleared", {31'd0, frame_error}, 0);
    wait_rx_rst(1'b1, "fe_rearm_rx_rst_high");
    rx_frame_error = 1'b0;
    wait_rx_rst(1'b0, "fe_rearm_rx_rst_low");
    chk("fe_after_rearm", {31'd0, frame_error}, 0);
    tick();
    rx_frame_error = 1'b1;
    tick(); tick();
    chk("fe_set_again", {31'd0, frame_error}, 1);
    chk("fe_prescale_kept", {16'd0, rx_prescale}, 32);

    // Disable with three bytes queued: flushed on the next edge.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b0);
    chk("dis_pre_tvalid", {31'd0, m_axis_tvalid}, 1);
    cfg_enable = 1'b0;
    tick();
    chk("dis_rx_rst", {31'd0, rx_rst}, 1);
    chk("dis_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("dis_rx_tready", {31'd0, rx_tready}, 0);

    // Asynchronous reset mid-stream.
    cfg_enable = 1'b1;
    tick(); tick(); tick();
    chk("reen_rx_rst", {31'd0, rx_rst}, 0);
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b0);
    chk("ar_pre_overrun", {31'd0, overrun}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rx_rst", {31'd0, rx_rst}, 1);
    chk("ar_prescale", {16'd0, rx_prescale}, 0);
    chk("ar_rx_tready", {31'd0, rx_tready}, 0);
    chk("ar_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("ar_tdata", {24'd0, m_axis_tdata}, 0);
    chk("ar_overrun", {31'd0, overrun}, 0);
    chk("ar_frame_error", {31'd0, frame_error}, 0);
    chk("ar_drop_count", {24'd0, drop_count}, 0);
    tick();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
